// File: rtl/soc_pkg.sv
// -----------------------------------------------------------------------------
// soc_pkg
// Shared definitions for the data-RAM port arbiter.
//   arb_state_t      : port ownership state (IDLE, OWN0, OWN1)
//   REQ_CORE/REQ_DMA : requester index constants (core = 0, JPEG DMA = 1)
//   MAXBURST_DEFAULT : default transfers per grant
//   own_state()      : maps a requester index to its ownership state
// -----------------------------------------------------------------------------
package soc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int REQ_CORE = 0;
  localparam int REQ_DMA  = 1;

  localparam int MAXBURST_DEFAULT = 8;

  function automatic arb_state_t own_state(input logic idx);
    return idx ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// ram_arbiter_if
// Bundles the two requester channels and the RAM port of the arbiter.
//   Requester side : req0/1, write0/1, last0/1, addr0/1, wdata0/1 (to arbiter)
//                    gnt0/1, rvalid0/1, rdata                     (from arbiter)
//   RAM side       : ramwrite, ramaddress, ramwritedata            (from arbiter)
//                    ramreaddata                                   (to arbiter)
// Modports:
//   master : requesters + RAM model (drives requests and read data)
//   slave  : the arbiter
// -----------------------------------------------------------------------------
interface ram_arbiter_if #(
  parameter int WIDTH = 32
);

  logic             req0;
  logic             req1;
  logic             write0;
  logic             write1;
  logic             last0;
  logic             last1;
  logic [WIDTH-1:0] addr0;
  logic [WIDTH-1:0] addr1;
  logic [WIDTH-1:0] wdata0;
  logic [WIDTH-1:0] wdata1;

  logic             gnt0;
  logic             gnt1;
  logic             rvalid0;
  logic             rvalid1;
  logic [WIDTH-1:0] rdata;

  logic             ramwrite;
  logic [WIDTH-1:0] ramaddress;
  logic [WIDTH-1:0] ramwritedata;
  logic [WIDTH-1:0] ramreaddata;

  modport master (
    output req0, req1, write0, write1, last0, last1,
    output addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
    input  ramwrite, ramaddress, ramwritedata,
    output ramreaddata
  );

  modport slave (
    input  req0, req1, write0, write1, last0, last1,
    input  addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
    output ramwrite, ramaddress, ramwritedata,
    input  ramreaddata
  );

endinterface

// File: rtl/ram_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational two-way chooser shared by the IDLE and release transitions.
//   i_req0, i_req1 : requests competing for the port
//   i_favour       : index that wins when both request
//   i_excl         : when set, the favoured index gives up its tie preference
//                    (it is still chosen if it is the only requester)
//   o_idx          : chosen requester index
//   o_valid        : at least one requester is asking
// -----------------------------------------------------------------------------
module arb_pick
  import soc_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_favour,
  input  logic i_excl,
  output logic o_idx,
  output logic o_valid
);

  logic w_pref;

  assign w_pref  = i_favour ^ i_excl;
  assign o_valid = i_req0 | i_req1;

  always_comb begin
    o_idx = 1'(REQ_CORE);
    if (i_req0 && i_req1) begin
      o_idx = w_pref;
    end else if (i_req1) begin
      o_idx = 1'(REQ_DMA);
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
// Shares the single data-RAM port between the RISC-V core (requester 0) and the
// JPEG DMA engine (requester 1). Grants are given in bursts of at most MAXBURST
// transfers; ties are broken round-robin. A transfer happens in any cycle where
// the owning requester holds req high. Loads return data one cycle later with a
// single-cycle rvalid strobe on the owning requester's channel.
//
// Ports:
//   clock  : system clock, rising edge
//   nreset : asynchronous active-low reset
//   bus    : ram_arbiter_if.slave (requester channels + RAM port)
//
// Parameters:
//   WIDTH    : data/address width (must match the interface instance)
//   MAXBURST : transfers per grant, 2..256
//
// Build option:
//   RAM_ARB_FIXED_PRIO_EN : when defined, requester 0 has fixed priority and
//   the round-robin pointer is removed. Requester 0 keeps the port across
//   burst-limit releases until it signals last0 or drops req0.
// -----------------------------------------------------------------------------
module ram_arbiter
  import soc_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAXBURST = MAXBURST_DEFAULT
) (
  input  logic          clock,
  input  logic          nreset,
  ram_arbiter_if.slave  bus
);

  localparam int                BCNT_W    = $clog2(MAXBURST);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(MAXBURST - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_t       r_state;
  logic [BCNT_W-1:0] r_bcnt;
  logic             r_rvalid0;
  logic             r_rvalid1;
  logic [WIDTH-1:0] r_addr_hold;
  logic [WIDTH-1:0] r_wdata_hold;
`ifndef RAM_ARB_FIXED_PRIO_EN
  logic             r_rr;
`endif

  // ---------------------------------------------------------------------------
  // Current owner's request channel
  // ---------------------------------------------------------------------------
  logic             w_own;
  logic             w_sel;
  logic             w_req_cur;
  logic             w_write_cur;
  logic             w_last_cur;
  logic [WIDTH-1:0] w_addr_cur;
  logic [WIDTH-1:0] w_wdata_cur;
  logic             w_xfer;
  logic             w_release;

  assign w_own = (r_state == OWN0) || (r_state == OWN1);
  assign w_sel = (r_state == OWN1);

  assign w_req_cur   = w_sel ? bus.req1   : bus.req0;
  assign w_write_cur = w_sel ? bus.write1 : bus.write0;
  assign w_last_cur  = w_sel ? bus.last1  : bus.last0;
  assign w_addr_cur  = w_sel ? bus.addr1  : bus.addr0;
  assign w_wdata_cur = w_sel ? bus.wdata1 : bus.wdata0;

  assign w_xfer = w_own && w_req_cur;

  // A dropped request releases without a transfer; last and the burst limit
  // only matter when a transfer happens, and that is implied once req is high.
  assign w_release = w_own &&
                     (!w_req_cur || w_last_cur || (r_bcnt == BCNT_LAST));

  // ---------------------------------------------------------------------------
  // Arbitration choice
  // ---------------------------------------------------------------------------
  logic w_favour;
  logic w_excl;
  logic w_pick_idx;
  logic w_pick_valid;

`ifdef RAM_ARB_FIXED_PRIO_EN
  // Core always wins ties, except right after it closed its own burst with
  // last0: then a waiting DMA gets its turn.
  assign w_favour = 1'(REQ_CORE);
  assign w_excl   = (r_state == OWN0) && w_xfer && w_last_cur;
`else
  // In IDLE the pointer decides. On release the pointer is about to move to
  // the other requester, so that requester is favoured in the same cycle.
  assign w_favour = w_own ? ~w_sel : r_rr;
  assign w_excl   = 1'b0;
`endif

  arb_pick u_pick (
    .i_req0   (bus.req0),
    .i_req1   (bus.req1),
    .i_favour (w_favour),
    .i_excl   (w_excl),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  arb_state_t w_state_next;

  always_comb begin
    w_state_next = r_state;
    if (!w_own || w_release) begin
      w_state_next = w_pick_valid ? own_state(w_pick_idx) : IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and registered side state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state      <= IDLE;
      r_bcnt       <= '0;
      r_rvalid0    <= 1'b0;
      r_rvalid1    <= 1'b0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      r_rr         <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;

      // Every release starts a fresh burst, even when re-granting the same
      // requester, so the counter never reaches MAXBURST.
      if (w_release) begin
        r_bcnt <= '0;
      end else if (w_xfer) begin
        r_bcnt <= r_bcnt + BCNT_W'(1);
      end

`ifndef RAM_ARB_FIXED_PRIO_EN
      if (w_release) begin
        r_rr <= ~w_sel;
      end
`endif

      if (w_xfer) begin
        r_addr_hold  <= w_addr_cur;
        r_wdata_hold <= w_wdata_cur;
      end

      r_rvalid0 <= w_xfer && !w_write_cur && !w_sel;
      r_rvalid1 <= w_xfer && !w_write_cur &&  w_sel;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.gnt0 = (r_state == OWN0);
  assign bus.gnt1 = (r_state == OWN1);

  // The address/data path must be valid in the transfer cycle itself because
  // the RAM samples it on the closing edge; between transfers it holds.
  assign bus.ramwrite     = w_xfer && w_write_cur;
  assign bus.ramaddress   = w_xfer ? w_addr_cur  : r_addr_hold;
  assign bus.ramwritedata = w_xfer ? w_wdata_cur : r_wdata_hold;

  assign bus.rvalid0 = r_rvalid0;
  assign bus.rvalid1 = r_rvalid1;
  assign bus.rdata   = bus.ramreaddata;

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
// Self-checking bench for ram_arbiter. A synchronous RAM model sits on the RAM
// port; a shadow copy of its contents supplies expected load data. A monitor
// pushes expected read data when a load transfer is seen and pops/compares it
// when rvalid arrives. Directed sequences check grant timing, bursts,
// round-robin fairness, the write path and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;

  localparam int WIDTH    = 32;
  localparam int MAXBURST = 8;

  logic clock = 1'b0;
  logic nreset;

  always #5 clock = ~clock;

  ram_arbiter_if #(.WIDTH(WIDTH)) bus ();

  ram_arbiter #(
    .WIDTH    (WIDTH),
    .MAXBURST (MAXBURST)
  ) dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus)
  );

  // ---------------------------------------------------------------------------
  // RAM model and shadow
  // ---------------------------------------------------------------------------
  logic [31:0] mem    [0:1023];
  logic [31:0] shadow [0:1023];

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  always @(posedge clock) begin
    if (bus.ramwrite) mem[bus.ramaddress[11:2]] <= bus.ramwritedata;
    bus.ramreaddata <= mem[bus.ramaddress[11:2]];
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor (runs 2 time units after every falling edge)
  // ---------------------------------------------------------------------------
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  bit          pend0 = 1'b0;
  bit          pend1 = 1'b0;

  task automatic mon_xfer(input int idx, input logic w, input logic [31:0] a,
                          input logic [31:0] d);
    logic [31:0] e;
    chk("xfer_ramaddress", bus.ramaddress, a);
    chk("xfer_ramwrite", 32'(bus.ramwrite), 32'(w));
    if (w) begin
      chk("xfer_ramwritedata", bus.ramwritedata, d);
      shadow[a[11:2]] = d;
      $display("xfer req%0d wr addr=0x%08h data=0x%08h", idx, a, d);
    end else begin
      e = shadow[a[11:2]];
      if (idx == 0) begin q0.push_back(e); pend0 = 1'b1; end
      else          begin q1.push_back(e); pend1 = 1'b1; end
      $display("xfer req%0d rd addr=0x%08h expect=0x%08h", idx, a, e);
    end
  endtask

  task automatic mon();
    logic [31:0] e;
    chk("gnt_onehot", 32'(bus.gnt0 & bus.gnt1), 32'd0);
    chk("rvalid0", 32'(bus.rvalid0), 32'(pend0));
    chk("rvalid1", 32'(bus.rvalid1), 32'(pend1));
    if (pend0) begin
      e = q0.pop_front();
      if (bus.rvalid0) chk("rdata0", bus.rdata, e);
    end
    if (pend1) begin
      e = q1.pop_front();
      if (bus.rvalid1) chk("rdata1", bus.rdata, e);
    end
    pend0 = 1'b0;
    pend1 = 1'b0;
    if (bus.req0 && bus.gnt0)
      mon_xfer(0, bus.write0, bus.addr0, bus.wdata0);
    else if (bus.req1 && bus.gnt1)
      mon_xfer(1, bus.write1, bus.addr1, bus.wdata1);
    else
      chk("idle_ramwrite", 32'(bus.ramwrite), 32'd0);
  endtask

  always @(negedge clock) begin
    #2;
    if (nreset) mon();
  end

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic drv0(input logic r, input logic w, input logic l,
                      input logic [31:0] a, input logic [31:0] d);
    bus.req0 = r; bus.write0 = w; bus.last0 = l; bus.addr0 = a; bus.wdata0 = d;
  endtask

  task automatic drv1(input logic r, input logic w, input logic l,
                      input logic [31:0] a, input logic [31:0] d);
    bus.req1 = r; bus.write1 = w; bus.last1 = l; bus.addr1 = a; bus.wdata1 = d;
  endtask

  task automatic idle(input int n);
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (n) @(negedge clock);
  endtask

  task automatic flush();
    q0.delete(); q1.delete();
    pend0 = 1'b0; pend1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    nreset = 1'b0;
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    flush();
    repeat (2) @(negedge clock);
    nreset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n0;
    int n1;
    logic e0;
    logic e1;

    for (int i = 0; i < 1024; i++) begin
      mem[i]    = init_word(i);
      shadow[i] = init_word(i);
    end
    bus.ramreaddata = 32'h0;
    nreset = 1'b1;
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2 nreset = 1'b0;

    // ---- reset values ----
    repeat (2) @(negedge clock);
    #1;
    chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
    chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
    chk("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
    chk("rst_ramwrite", 32'(bus.ramwrite), 32'd0);
    chk("rst_ramaddress", bus.ramaddress, 32'h0);
    chk("rst_ramwritedata", bus.ramwritedata, 32'h0);
    @(negedge clock);
    nreset = 1'b1;

    // ---- single core load ----
    @(negedge clock); drv0(1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
    #1 chk("load_gnt0_t0", 32'(bus.gnt0), 32'd0);
    @(negedge clock);
    #1 chk("load_gnt0_t1", 32'(bus.gnt0), 32'd1);
    chk("load_addr_t1", bus.ramaddress, 32'h40);
    @(negedge clock); drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 chk("load_rvalid0_t2", 32'(bus.rvalid0), 32'd1);
    chk("load_rdata_t2", bus.rdata, init_word(32'h40 >> 2));
    @(negedge clock);
    #1 chk("load_idle_t3", 32'(bus.gnt0), 32'd0);
`ifndef RAM_ARB_FIXED_PRIO_EN
    // pointer now favours requester 1: a tie from IDLE goes to the DMA
    drv0(1'b1, 1'b0, 1'b1, 32'h54, 32'h0);
    drv1(1'b1, 1'b0, 1'b1, 32'h88, 32'h0);
    @(negedge clock);
    #1 chk("rr_tie_gnt1", 32'(bus.gnt1), 32'd1);
    @(negedge clock); drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 chk("rr_handover_gnt0", 32'(bus.gnt0), 32'd1);
    @(negedge clock); drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
`endif
    idle(3);

    // ---- tie from reset, 3-word core burst, zero-bubble handover ----
    do_reset();
    @(negedge clock);
    drv0(1'b1, 1'b0, 1'b0, 32'h44, 32'h0);
    drv1(1'b1, 1'b0, 1'b0, 32'h80, 32'h0);
    #1 chk("tie_gnt0_t0", 32'(bus.gnt0), 32'd0);
    chk("tie_gnt1_t0", 32'(bus.gnt1), 32'd0);
    @(negedge clock);
    #1 chk("tie_gnt0_t1", 32'(bus.gnt0), 32'd1);
    @(negedge clock); drv0(1'b1, 1'b0, 1'b0, 32'h48, 32'h0);
    #1 chk("tie_gnt0_t2", 32'(bus.gnt0), 32'd1);
    @(negedge clock); drv0(1'b1, 1'b0, 1'b1, 32'h4C, 32'h0);
    #1 chk("tie_gnt0_t3", 32'(bus.gnt0), 32'd1);
    @(negedge clock);
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv1(1'b1, 1'b0, 1'b1, 32'h80, 32'h0);
    #1 chk("tie_gnt1_t4", 32'(bus.gnt1), 32'd1);
    chk("tie_gnt0_t4", 32'(bus.gnt0), 32'd0);
    @(negedge clock); drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 chk("tie_regrant1_t5", 32'(bus.gnt1), 32'd1);
    @(negedge clock);
    #1 chk("tie_idle_t6", 32'(bus.gnt0 | bus.gnt1), 32'd0);
    drv0(1'b1, 1'b0, 1'b1, 32'h50, 32'h0);
    drv1(1'b1, 1'b0, 1'b1, 32'h84, 32'h0);
    @(negedge clock);
    #1 chk("tie2_gnt0", 32'(bus.gnt0), 32'd1);
    @(negedge clock); drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 chk("tie2_gnt1", 32'(bus.gnt1), 32'd1);
    @(negedge clock); drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(3);

    // ---- burst cap: DMA alone for 20 cycles ----
    do_reset();
    n1 = 0;
    for (int k = 0; k < 22; k++) begin
      @(negedge clock);
      if (k < 20) drv1(1'b1, 1'b0, 1'b0, 32'h200 + 32'(4 * n1), 32'h0);
      else        drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1 chk("cap_gnt1", 32'(bus.gnt1), 32'((k >= 1) && (k <= 20)));
      if (bus.gnt1 && bus.req1) n1++;
    end
    chk("cap_xfer_count", 32'(n1), 32'd19);
    idle(3);

    // ---- starvation: both requesters always asking ----
    do_reset();
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 41; k++) begin
      @(negedge clock);
      drv0(1'b1, 1'b0, 1'b0, 32'h400 + 32'(4 * n0), 32'h0);
      drv1(1'b1, 1'b0, 1'b0, 32'h800 + 32'(4 * n1), 32'h0);
      #1;
`ifdef RAM_ARB_FIXED_PRIO_EN
      e0 = (k >= 1);
      e1 = 1'b0;
`else
      e0 = (k >= 1) && ((((k - 1) / MAXBURST) % 2) == 0);
      e1 = (k >= 1) && !e0;
`endif
      chk("starve_gnt0", 32'(bus.gnt0), 32'(e0));
      chk("starve_gnt1", 32'(bus.gnt1), 32'(e1));
      if (bus.gnt0) n0++;
      if (bus.gnt1) n1++;
    end
    idle(3);

    // ---- write path, then core reads it back ----
    @(negedge clock); drv1(1'b1, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
    #1 chk("wr_ramwrite_t0", 32'(bus.ramwrite), 32'd0);
    @(negedge clock);
    #1 chk("wr_gnt1", 32'(bus.gnt1), 32'd1);
    chk("wr_ramwrite_t1", 32'(bus.ramwrite), 32'd1);
    chk("wr_ramaddress", bus.ramaddress, 32'h100);
    chk("wr_ramwritedata", bus.ramwritedata, 32'hDEADBEEF);
    @(negedge clock); drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 chk("wr_ramwrite_t2", 32'(bus.ramwrite), 32'd0);
    @(negedge clock); drv0(1'b1, 1'b0, 1'b1, 32'h100, 32'h0);
    @(negedge clock);
    #1 chk("rb_gnt0", 32'(bus.gnt0), 32'd1);
    chk("rb_ramaddress", bus.ramaddress, 32'h100);
    @(negedge clock); drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 chk("rb_rvalid0", 32'(bus.rvalid0), 32'd1);
    chk("rb_rdata", bus.rdata, 32'hDEADBEEF);
    idle(3);

    // ---- reset in the middle of a DMA read burst ----
    do_reset();
    @(negedge clock); drv1(1'b1, 1'b0, 1'b0, 32'h300, 32'h12345678);
    #1 chk("mid_gnt1_t0", 32'(bus.gnt1), 32'd0);
    @(negedge clock);
    #1 chk("mid_gnt1_t1", 32'(bus.gnt1), 32'd1);
    @(negedge clock); drv1(1'b1, 1'b0, 1'b0, 32'h304, 32'h12345678);
    #1 chk("mid_gnt1_t2", 32'(bus.gnt1), 32'd1);
    #2;
    nreset = 1'b0;
    flush();
    #1;
    chk("mid_rst_gnt1", 32'(bus.gnt1), 32'd0);
    chk("mid_rst_rvalid1", 32'(bus.rvalid1), 32'd0);
    chk("mid_rst_ramwrite", 32'(bus.ramwrite), 32'd0);
    chk("mid_rst_ramaddress", bus.ramaddress, 32'h0);
    chk("mid_rst_ramwritedata", bus.ramwritedata, 32'h0);
    @(negedge clock); drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 chk("mid_hold_rvalid1", 32'(bus.rvalid1), 32'd0);
    @(negedge clock); nreset = 1'b1;
    #1 chk("mid_rel_rvalid1", 32'(bus.rvalid1), 32'd0);
    chk("mid_rel_gnt1", 32'(bus.gnt1), 32'd0);
    @(negedge clock);
    drv0(1'b1, 1'b0, 1'b1, 32'h58, 32'h0);
    drv1(1'b1, 1'b0, 1'b1, 32'h8C, 32'h0);
    @(negedge clock);
    #1 chk("mid_tie_gnt0", 32'(bus.gnt0), 32'd1);
    @(negedge clock); drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 chk("mid_tie_gnt1", 32'(bus.gnt1), 32'd1);
    @(negedge clock); drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(4);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
